// File: rtl/memoria_dados_pkg.sv
// Shared types and constants for the parametrised data memory.
// Covers access-size codes, FSM states and the words preloaded during init.
package memoria_dados_pkg;

  typedef enum logic [1:0] {
    TAM_BYTE = 2'b00,
    TAM_HALF = 2'b01,
    TAM_WORD = 2'b10,
    TAM_RSVD = 2'b11
  } tamanho_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } estado_t;

  localparam logic [31:0] PRESET0 = 32'h0000_0007;
  localparam logic [31:0] PRESET1 = 32'h0000_0041;
  localparam logic [31:0] PRESET2 = 32'h0000_0051;
  localparam logic [31:0] PRESET3 = 32'h0000_0049;

  function automatic logic [31:0] preset_word(input logic [1:0] idx);
    case (idx)
      2'd0:    return PRESET0;
      2'd1:    return PRESET1;
      2'd2:    return PRESET2;
      default: return PRESET3;
    endcase
  endfunction

endpackage

// File: rtl/memoria_dados_alinhador.sv
// Lane steering for one 32-bit word: store merge, byte mask, load extract/extend.
// The load path reads the merged word so a simultaneous store is seen (write-first).
module memoria_dados_alinhador
  import memoria_dados_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  tamanho,
  input  logic        sem_sinal,
  input  logic        escreve,
  input  logic [31:0] palavra,
  input  logic [31:0] dados,
  output logic [31:0] mesclada,
  output logic [3:0]  mascara,
  output logic [31:0] carga,
  output logic        desalinhado
);

  logic [31:0] dados_desl;
  logic [31:0] desl;

  // The reserved size code is flagged here too so the top sees one "bad shape" bit.
  always_comb begin
    mascara     = 4'b0000;
    desalinhado = 1'b0;
    case (tamanho)
      TAM_BYTE: mascara = 4'b0001 << offset;
      TAM_HALF: begin
        mascara     = 4'b0011 << offset;
        desalinhado = offset[0];
      end
      TAM_WORD: begin
        mascara     = 4'b1111;
        desalinhado = |offset;
      end
      default:  desalinhado = 1'b1;
    endcase
  end

  assign dados_desl = dados << {offset, 3'b000};

  always_comb begin
    mesclada = palavra;
    for (int k = 0; k < 4; k++)
      if (escreve && mascara[k]) mesclada[8*k +: 8] = dados_desl[8*k +: 8];
  end

  assign desl = mesclada >> {offset, 3'b000};

  always_comb begin
    carga = desl;
    case (tamanho)
      TAM_BYTE: carga = {{24{~sem_sinal & desl[7]}}, desl[7:0]};
      TAM_HALF: carga = {{16{~sem_sinal & desl[15]}}, desl[15:0]};
      default:  carga = desl;
    endcase
  end

endmodule

// File: rtl/memoria_dados_param.sv
// Byte-addressed data memory with sized/extended loads, error flag and
// a sequenced post-reset initialisation; all state moves on the falling edge.
module memoria_dados_param
  import memoria_dados_pkg::*;
#(
  parameter int DEPTH         = 128,
  parameter int ADDR_WIDTH    = 32,
  parameter bit PRESET_ENABLE = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] Endereco,
  input  logic [31:0]           DadosEscrita,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            Tamanho,
  input  logic                  SemSinal,
  output logic [31:0]           ReadData,
  output logic                  Pronto,
  output logic                  Erro
);

  localparam int IW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  estado_t       estado, estado_prox;
  logic [IW-1:0] cnt, cnt_prox;
  logic [IW-1:0] indice;
  logic          fora, pedido, desalinhado;
  logic [31:0]   palavra, mesclada, carga;
  logic [3:0]    mascara;

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [31:0]   wr_data;
  logic [3:0]    wr_mask;
  logic [31:0]   rd_prox;
  logic          erro_prox, pronto_prox;

  assign indice  = Endereco[IW+1:2];
  assign fora    = (Endereco >> (IW + 2)) != '0;
  assign pedido  = MemRead | MemWrite;
  assign palavra = mem[indice];

  memoria_dados_alinhador u_alinhador (
    .offset      (Endereco[1:0]),
    .tamanho     (Tamanho),
    .sem_sinal   (SemSinal),
    .escreve     (MemWrite),
    .palavra     (palavra),
    .dados       (DadosEscrita),
    .mesclada    (mesclada),
    .mascara     (mascara),
    .carga       (carga),
    .desalinhado (desalinhado)
  );

  always_comb begin
    estado_prox = estado;
    cnt_prox    = cnt;
    wr_en       = 1'b0;
    wr_idx      = indice;
    wr_data     = mesclada;
    wr_mask     = mascara;
    rd_prox     = ReadData;
    erro_prox   = 1'b0;
    pronto_prox = Pronto;
    case (estado)
      ST_INIT: begin
        wr_en    = 1'b1;
        wr_idx   = cnt;
        wr_mask  = 4'b1111;
        wr_data  = (PRESET_ENABLE && int'(cnt) < 4) ? preset_word(cnt[1:0]) : 32'h0;
        cnt_prox = cnt + 1'b1;
        if (cnt == IW'(DEPTH - 1)) begin
          estado_prox = ST_RUN;
          pronto_prox = 1'b1;
        end
      end
      default: begin
        if (pedido) begin
          if (fora || desalinhado) begin
            erro_prox = 1'b1;
          end else begin
            wr_en = MemWrite;
            if (MemRead) rd_prox = carga;
          end
        end
      end
    endcase
  end

  always_ff @(negedge Clock) begin
    if (Reset) begin
      estado   <= ST_INIT;
      cnt      <= '0;
      ReadData <= 32'h0;
      Pronto   <= 1'b0;
      Erro     <= 1'b0;
    end else begin
      estado   <= estado_prox;
      cnt      <= cnt_prox;
      ReadData <= rd_prox;
      Pronto   <= pronto_prox;
      Erro     <= erro_prox;
    end
  end

  // Array has no reset of its own; init sequencing clears it instead.
  always_ff @(negedge Clock) begin
    if (!Reset && wr_en)
      for (int k = 0; k < 4; k++)
        if (wr_mask[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
  end

endmodule

// File: tb/tb_memoria_dados_param.sv
// Directed plus randomized bench for memoria_dados_param against a byte-array model.
module tb_memoria_dados_param;
  localparam int DEPTH = 128;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Endereco = '0;
  logic [31:0] DadosEscrita = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [1:0]  Tamanho = 2'b10;
  logic        SemSinal = 1'b0;
  logic [31:0] ReadData;
  logic        Pronto;
  logic        Erro;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mb [4*DEPTH];
  logic [31:0] m_rd;
  logic        m_err;
  logic [31:0] presets [4] = '{32'h7, 32'h41, 32'h51, 32'h49};

  always #5 Clock = ~Clock;

  memoria_dados_param #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .PRESET_ENABLE(1'b1)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Endereco     (Endereco),
    .DadosEscrita (DadosEscrita),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .Tamanho      (Tamanho),
    .SemSinal     (SemSinal),
    .ReadData     (ReadData),
    .Pronto       (Pronto),
    .Erro         (Erro)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h00;
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++) mb[4*w+b] = presets[w][8*b +: 8];
    m_rd  = 32'h0;
    m_err = 1'b0;
  endtask

  // Model works on a flat byte array: an access is nb consecutive bytes from addr.
  task automatic model_step(input bit rd, input bit wr, input logic [1:0] tam, input bit sem,
                            input logic [31:0] addr, input logic [31:0] data);
    int unsigned nb;
    logic [31:0] v;
    if (!(rd || wr)) begin
      m_err = 1'b0;
      return;
    end
    nb = (tam == 2'b00) ? 1 : (tam == 2'b01) ? 2 : 4;
    if (addr >= 32'(4*DEPTH) || tam == 2'b11 || (addr % nb) != 0) begin
      m_err = 1'b1;
      return;
    end
    m_err = 1'b0;
    if (wr)
      for (int i = 0; i < int'(nb); i++) mb[int'(addr) + i] = data[8*i +: 8];
    if (rd) begin
      v = 32'h0;
      for (int i = 0; i < int'(nb); i++) v[8*i +: 8] = mb[int'(addr) + i];
      if (!sem && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      m_rd = v;
    end
  endtask

  task automatic idle_inputs();
    MemRead = 1'b0; MemWrite = 1'b0; Endereco = '0; DadosEscrita = '0;
    Tamanho = 2'b10; SemSinal = 1'b0;
  endtask

  task automatic acc(input string tag, input bit rd, input bit wr, input logic [1:0] tam,
                     input bit sem, input logic [31:0] addr, input logic [31:0] data);
    @(posedge Clock);
    MemRead = rd; MemWrite = wr; Tamanho = tam; SemSinal = sem;
    Endereco = addr; DadosEscrita = data;
    @(negedge Clock); #1;
    model_step(rd, wr, tam, sem, addr, data);
    chk({tag, ".rd"}, ReadData, m_rd);
    chk({tag, ".erro"}, 32'(Erro), 32'(m_err));
  endtask

  task automatic apply_reset();
    @(posedge Clock);
    Reset = 1'b1;
    idle_inputs();
    @(negedge Clock);
    @(posedge Clock);
    @(negedge Clock); #1;
    chk("reset.rd", ReadData, 32'h0);
    chk("reset.pronto", 32'(Pronto), 32'h0);
    chk("reset.erro", 32'(Erro), 32'h0);
    model_reset();
  endtask

  // Init edges with a junk store/load presented on every edge; abort_at>0 re-asserts reset there.
  task automatic run_init(input int abort_at);
    for (int e = 1; e <= DEPTH; e++) begin
      @(posedge Clock);
      Reset = (e == abort_at);
      MemRead = 1'b1; MemWrite = 1'b1; Tamanho = 2'b10; SemSinal = 1'b0;
      Endereco = 32'h40; DadosEscrita = 32'h1234_5678;
      @(negedge Clock); #1;
      if (e == abort_at) begin
        chk("abort.pronto", 32'(Pronto), 32'h0);
        chk("abort.rd", ReadData, 32'h0);
        chk("abort.erro", 32'(Erro), 32'h0);
        model_reset();
        return;
      end
      chk("init.pronto", 32'(Pronto), 32'(e == DEPTH));
      chk("init.rd", ReadData, 32'h0);
      chk("init.erro", 32'(Erro), 32'h0);
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  t;
    bit          r, w, s;

    apply_reset();
    run_init(0);

    acc("ld0", 1, 0, 2'b10, 0, 32'h0,  32'h0); chk("ld0.val", ReadData, 32'h7);
    acc("ld4", 1, 0, 2'b10, 0, 32'h4,  32'h0); chk("ld4.val", ReadData, 32'h41);
    acc("ld8", 1, 0, 2'b10, 0, 32'h8,  32'h0); chk("ld8.val", ReadData, 32'h51);
    acc("ldC", 1, 0, 2'b10, 0, 32'hC,  32'h0); chk("ldC.val", ReadData, 32'h49);
    acc("ld10", 1, 0, 2'b10, 0, 32'h10, 32'h0); chk("ld10.val", ReadData, 32'h0);

    acc("sw20", 0, 1, 2'b10, 0, 32'h20, 32'h1122_3344);
    acc("sb21", 0, 1, 2'b00, 0, 32'h21, 32'hFFFF_FFF0);
    acc("lw20", 1, 0, 2'b10, 0, 32'h20, 32'h0); chk("lw20.val", ReadData, 32'h1122_F044);
    acc("lb21", 1, 0, 2'b00, 0, 32'h21, 32'h0); chk("lb21.val", ReadData, 32'hFFFF_FFF0);
    acc("lbu21", 1, 0, 2'b00, 1, 32'h21, 32'h0); chk("lbu21.val", ReadData, 32'h0000_00F0);
    chk("lbu21.erro0", 32'(Erro), 32'h0);

    acc("sh22", 0, 1, 2'b01, 0, 32'h22, 32'h5555_8001);
    acc("lw20b", 1, 0, 2'b10, 0, 32'h20, 32'h0); chk("lw20b.val", ReadData, 32'h8001_F044);
    acc("lh22", 1, 0, 2'b01, 0, 32'h22, 32'h0); chk("lh22.val", ReadData, 32'hFFFF_8001);
    acc("lhu22", 1, 0, 2'b01, 1, 32'h22, 32'h0); chk("lhu22.val", ReadData, 32'h0000_8001);

    acc("e_lw22", 1, 0, 2'b10, 0, 32'h22, 32'h0);
    chk("e_lw22.erro1", 32'(Erro), 32'h1); chk("e_lw22.hold", ReadData, 32'h0000_8001);
    acc("e_ok1", 1, 0, 2'b10, 0, 32'h4, 32'h0); chk("e_ok1.erro0", 32'(Erro), 32'h0);
    acc("e_sw200", 0, 1, 2'b10, 0, 32'h200, 32'hAAAA_AAAA);
    chk("e_sw200.erro1", 32'(Erro), 32'h1); chk("e_sw200.hold", ReadData, 32'h41);
    acc("e_ok2", 1, 0, 2'b10, 0, 32'h0, 32'h0);
    chk("e_ok2.word0", ReadData, 32'h7); chk("e_ok2.erro0", 32'(Erro), 32'h0);
    acc("e_rsvd", 1, 0, 2'b11, 0, 32'h0, 32'h0);
    chk("e_rsvd.erro1", 32'(Erro), 32'h1); chk("e_rsvd.hold", ReadData, 32'h7);
    acc("e_ok3", 1, 0, 2'b01, 1, 32'h2, 32'h0); chk("e_ok3.erro0", 32'(Erro), 32'h0);

    acc("rw30", 1, 1, 2'b10, 0, 32'h30, 32'hDEAD_BEEF); chk("rw30.val", ReadData, 32'hDEAD_BEEF);
    acc("rwb31", 1, 1, 2'b00, 0, 32'h31, 32'h0000_0080); chk("rwb31.val", ReadData, 32'hFFFF_FF80);

    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 4*DEPTH + 15));
      t = 2'($urandom_range(0, 3));
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      d = $urandom();
      acc("rnd", r, w, t, s, a, d);
    end
    for (int i = 0; i < DEPTH; i++) acc("sweep", 1, 0, 2'b10, 0, 32'(4*i), 32'h0);

    apply_reset();
    run_init(50);
    run_init(0);
    acc("ld40", 1, 0, 2'b10, 0, 32'h40, 32'h0); chk("ld40.val", ReadData, 32'h0);
    for (int i = 0; i < DEPTH; i++) acc("sweep2", 1, 0, 2'b10, 0, 32'(4*i), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memoria_dados_param.md
Name: memoria_dados_param

Overview:
Parametrised data memory for the single-cycle datapath and successor to the fixed 128-word data memory. It adds byte addressing, byte/half/word access sizes with signed or unsigned extension, and alignment and range error detection. A synchronous reset triggers a sequenced initialisation that clears the array and loads preset words, with a ready flag. It sits between the ALU result (address), register-file read data (store data) and the write-back mux.

Parameters:
DEPTH, 128, number of 32-bit words; must be a power of two and at least 4
ADDR_WIDTH, 32, width of the byte address input
PRESET_ENABLE, 1, 1 = load preset words 0..3 during init; 0 = clear all words to zero

Ports:
Clock  in  1  system clock; all state updates on the falling edge
Reset  in  1  synchronous, active-high reset, sampled on the falling edge of Clock
Endereco  in  ADDR_WIDTH  byte address (ALU result)
DadosEscrita  in  32  store data; a byte store uses [7:0], a half store uses [15:0]
MemRead  in  1  load request
MemWrite  in  1  store request
Tamanho  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved
SemSinal  in  1  1 = zero-extend loads, 0 = sign-extend loads; ignored for word accesses
ReadData  out  32  registered load result
Pronto  out  1  1 = initialisation done, accesses accepted
Erro  out  1  registered: previous edge carried an invalid request

Behaviour:
- Single clock; registers update on the falling edge of Clock. Reset is synchronous and active-high.
- Reset (any state, including mid-init): state <= INIT, init counter <= 0, ReadData <= 0, Pronto <= 0, Erro <= 0. No array write occurs on a reset edge.
- FSM states: INIT and RUN.
- INIT: each edge writes word[cnt] and increments cnt.
  - Value written: PRESET[cnt] if PRESET_ENABLE and cnt<4, else 0.
  - Preset values: 0x00000007, 0x00000041, 0x00000051, 0x00000049.
  - On the edge that writes word DEPTH-1: state <= RUN, Pronto <= 1.
  - Result: Pronto rises on the DEPTH-th edge after Reset deasserts.
  - MemRead/MemWrite are ignored in INIT; ReadData and Erro hold 0.
- RUN, address decode:
  - Word index = Endereco >> 2; lane offset = Endereco[1:0]; little-endian, byte k = bits [8k+7:8k].
- RUN, request validity: a request (MemRead or MemWrite) is invalid if any of the following holds:
  - Endereco >= 4*DEPTH (upper bits nonzero);
  - Tamanho=11;
  - half with Endereco[0]=1;
  - word with Endereco[1:0]!=0.
- Invalid request:
  - store suppressed; ReadData holds; Erro <= 1.
- Valid request, or no request: Erro <= 0.
- Valid store: only the addressed lanes are updated (1, 2 or 4 bytes); other lanes are preserved.
- Valid load:
  - ReadData <= selected lanes, right-justified and extended per SemSinal.
  - Visible immediately after the same falling edge, so data is usable by the following rising edge.
- MemRead and MemWrite together on a valid request: write-first. ReadData returns the merged post-write word, then extracted and extended.
- No MemRead: ReadData holds its previous value.
- Any lanes not covered by the access size are don't-care on input; outputs are always fully driven.

Decomposition:
- Package memoria_dados_pkg:
  - size codes TAM_BYTE, TAM_HALF, TAM_WORD, TAM_RSVD;
  - FSM state enum;
  - preset word constants.
- Combinational sub-module memoria_dados_alinhador:
  - inputs: lane offset, size, SemSinal, stored word, store data;
  - outputs: merged write word, byte-write mask, extended load value, misalignment flag.
- The top level holds the FSM, init counter, array, range check and output registers.

Test Plan:
- Reset high 2 edges then release -> Pronto=0 for 127 edges and 1 on the 128th. Word loads at 0x0/0x4/0x8/0xC/0x10 -> 0x00000007/0x41/0x51/0x49/0x0.
- Word store 0x11223344 @0x20, then byte store 0xF0 @0x21 -> word load @0x20 = 0x1122F044; signed byte load @0x21 = 0xFFFFFFF0; unsigned byte load = 0x000000F0; Erro=0.
- Half store 0x8001 @0x22 -> word load @0x20 = 0x8001F044; signed half load @0x22 = 0xFFFF8001; unsigned = 0x00008001.
- Error cases, each -> Erro=1 for one edge, ReadData unchanged, Erro=0 on the next valid access:
  - word load @0x22;
  - word store 0xAAAAAAAA @0x200 (word @0x0 still 0x7);
  - Tamanho=11 @0x0.
- MemRead+MemWrite, word 0xDEADBEEF @0x30 on the same edge -> ReadData=0xDEADBEEF after that edge.
- Reset reasserted at init edge 50; word store 0x12345678 @0x40 during init -> Pronto low for a full 128 edges after release; word load @0x40 = 0x00000000; Erro stayed 0 throughout.
